// File: rtl/jtframe_vtimer_ctrl.sv
// jtframe_vtimer_ctrl
// Video timing sequencer. Divides clk into pixel clock enables, runs the H/V
// pixel counters and produces LHBL/LVBL/HS/VS plus a frame toggle. Every
// output is registered. The decodes come from the next-count values, so they
// always match the hcnt/vcnt presented in the same cycle.
module jtframe_vtimer_ctrl #(
  parameter int unsigned CEN_DIV  = 4,
  parameter int unsigned HW       = 9,
  parameter int unsigned VW       = 9,
  parameter int unsigned HTOTAL   = 384,
  parameter int unsigned HB_START = 256,
  parameter int unsigned HB_END   = 0,
  parameter int unsigned HS_START = 288,
  parameter int unsigned HS_END   = 320,
  parameter int unsigned VTOTAL   = 264,
  parameter int unsigned VB_START = 240,
  parameter int unsigned VB_END   = 16,
  parameter int unsigned VS_START = 248,
  parameter int unsigned VS_END   = 251
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          pxl_cen,
  output logic          pxl2_cen,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          LHBL,
  output logic          LVBL,
  output logic          HS,
  output logic          VS,
  output logic          frame
);

  localparam int unsigned CW = $clog2(CEN_DIV);

  if (CEN_DIV < 2 || (CEN_DIV % 2) != 0) begin : g_bad_div
    $error("jtframe_vtimer_ctrl: CEN_DIV must be even and at least 2");
  end
  if (HTOTAL > (2 ** HW) || VTOTAL > (2 ** VW)) begin : g_bad_width
    $error("jtframe_vtimer_ctrl: HTOTAL/VTOTAL do not fit in HW/VW bits");
  end
  if (!(HB_END < HB_START && HB_START < HTOTAL)) begin : g_bad_hblank
    $error("jtframe_vtimer_ctrl: need HB_END < HB_START < HTOTAL");
  end
  if (!(VB_END < VB_START && VB_START < VTOTAL)) begin : g_bad_vblank
    $error("jtframe_vtimer_ctrl: need VB_END < VB_START < VTOTAL");
  end

  // True when lo <= x < hi. Used for visible areas and sync windows.
  function automatic logic in_win(input int unsigned x, input int unsigned lo,
                                  input int unsigned hi);
    return (x >= lo) && (x < hi);
  endfunction

  logic [CW-1:0] div_cnt;
  logic          div_last;
  logic          div_half;
  logic          h_wrap;
  logic          v_wrap;
  logic [HW-1:0] h_nxt;
  logic [VW-1:0] v_nxt;

  assign div_last = (div_cnt == CW'(CEN_DIV - 1));
  assign div_half = (div_cnt == CW'(CEN_DIV / 2 - 1));

  // Next counter values. Outputs are decoded from these values, so the decode
  // does not lag the counter by one pixel.
  always_comb begin
    h_wrap = (hcnt == HW'(HTOTAL - 1));
    v_wrap = (vcnt == VW'(VTOTAL - 1));
    h_nxt  = h_wrap ? '0 : hcnt + 1'b1;
    v_nxt  = vcnt;
    if (h_wrap) v_nxt = v_wrap ? '0 : vcnt + 1'b1;
  end

  // Clock-enable divider. It freezes at its current count while disabled, so
  // resuming neither drops nor repeats a pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      pxl_cen  <= 1'b0;
      pxl2_cen <= 1'b0;
    end else if (!enable) begin
      pxl_cen  <= 1'b0;
      pxl2_cen <= 1'b0;
    end else begin
      div_cnt  <= div_last ? '0 : div_cnt + 1'b1;
      pxl_cen  <= div_last;
      pxl2_cen <= div_last | div_half;
    end
  end

  // Pixel/line counters and timing decodes. They advance on each issued
  // pxl_cen. A pulse already presented downstream is always consumed, even if
  // enable drops on that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt  <= '0;
      vcnt  <= '0;
      frame <= 1'b0;
      LHBL  <= in_win(0, HB_END, HB_START);
      LVBL  <= in_win(0, VB_END, VB_START);
      HS    <= in_win(0, HS_START, HS_END);
      VS    <= in_win(0, VS_START, VS_END);
    end else if (pxl_cen) begin
      hcnt <= h_nxt;
      vcnt <= v_nxt;
      if (h_wrap && v_wrap) frame <= ~frame;
      LHBL <= in_win(32'(h_nxt), HB_END, HB_START);
      LVBL <= in_win(32'(v_nxt), VB_END, VB_START);
      HS   <= in_win(32'(h_nxt), HS_START, HS_END);
      VS   <= in_win(32'(v_nxt), VS_START, VS_END);
    end
  end

endmodule

// File: tb/tb_jtframe_vtimer_ctrl.sv
// Bench for jtframe_vtimer_ctrl. Three builds share clk/rst/enable:
//   u0: default timing
//   u1: tiny corner build (CEN_DIV=2, 8x4 raster, counters exactly full width)
//   u2: default vertical timing with a short line, so a full frame fits
// The reference model counts enabled clock edges since reset. From that count
// it derives pixel count, position, frame parity and window decodes.
module tb_jtframe_vtimer_ctrl;

  localparam int D   [3] = '{4, 2, 2};
  localparam int HT  [3] = '{384, 8, 16};
  localparam int HBS [3] = '{256, 6, 10};
  localparam int HBE [3] = '{0, 1, 2};
  localparam int HSS [3] = '{288, 6, 12};
  localparam int HSE [3] = '{320, 8, 14};
  localparam int VT  [3] = '{264, 4, 264};
  localparam int VBS [3] = '{240, 3, 240};
  localparam int VBE [3] = '{16, 1, 16};
  localparam int VSS [3] = '{248, 3, 248};
  localparam int VSE [3] = '{251, 4, 251};

  logic       clk, rst, enable;
  logic [2:0] cen_o, cen2_o, lhbl_o, lvbl_o, hs_o, vs_o, fr_o;
  logic [8:0] h0, v0, h2, v2;
  logic [2:0] h1;
  logic [1:0] v1;

  int     checks, failures;
  longint n;
  int     pc [3];
  int     p2 [3];

  jtframe_vtimer_ctrl u0 (
    .clk(clk), .rst(rst), .enable(enable), .pxl_cen(cen_o[0]), .pxl2_cen(cen2_o[0]),
    .hcnt(h0), .vcnt(v0), .LHBL(lhbl_o[0]), .LVBL(lvbl_o[0]), .HS(hs_o[0]),
    .VS(vs_o[0]), .frame(fr_o[0]));

  jtframe_vtimer_ctrl #(
    .CEN_DIV(2), .HW(3), .VW(2), .HTOTAL(8), .HB_START(6), .HB_END(1),
    .HS_START(6), .HS_END(8), .VTOTAL(4), .VB_START(3), .VB_END(1),
    .VS_START(3), .VS_END(4)
  ) u1 (
    .clk(clk), .rst(rst), .enable(enable), .pxl_cen(cen_o[1]), .pxl2_cen(cen2_o[1]),
    .hcnt(h1), .vcnt(v1), .LHBL(lhbl_o[1]), .LVBL(lvbl_o[1]), .HS(hs_o[1]),
    .VS(vs_o[1]), .frame(fr_o[1]));

  jtframe_vtimer_ctrl #(
    .CEN_DIV(2), .HTOTAL(16), .HB_START(10), .HB_END(2), .HS_START(12), .HS_END(14)
  ) u2 (
    .clk(clk), .rst(rst), .enable(enable), .pxl_cen(cen_o[2]), .pxl2_cen(cen2_o[2]),
    .hcnt(h2), .vcnt(v2), .LHBL(lhbl_o[2]), .LVBL(lvbl_o[2]), .HS(hs_o[2]),
    .VS(vs_o[2]), .frame(fr_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Expected raster state for build i after nn enabled edges, with c = cen pending.
  function automatic void expect_state(input int i, input longint nn, input int c,
      output int h, output int v, output int lh, output int lv, output int hs,
      output int vs, output int fr);
    longint p, line;
    p    = nn / D[i] - c;
    h    = int'(p % HT[i]);
    line = p / HT[i];
    v    = int'(line % VT[i]);
    fr   = int'((line / VT[i]) % 2);
    lh   = int'(h >= HBE[i] && h < HBS[i]);
    lv   = int'(v >= VBE[i] && v < VBS[i]);
    hs   = int'(h >= HSS[i] && h < HSE[i]);
    vs   = int'(v >= VSS[i] && v < VSE[i]);
  endfunction

  task automatic compare_all();
    int eh, ev, elh, elv, ehs, evs, efr, ah, av;
    for (int i = 0; i < 3; i++) begin
      expect_state(i, n, pc[i], eh, ev, elh, elv, ehs, evs, efr);
      case (i)
        0:       begin ah = int'(h0); av = int'(v0); end
        1:       begin ah = int'(h1); av = int'(v1); end
        default: begin ah = int'(h2); av = int'(v2); end
      endcase
      chk($sformatf("u%0d.pxl_cen", i),  int'(cen_o[i]),  pc[i]);
      chk($sformatf("u%0d.pxl2_cen", i), int'(cen2_o[i]), p2[i]);
      chk($sformatf("u%0d.hcnt", i),     ah,               eh);
      chk($sformatf("u%0d.vcnt", i),     av,               ev);
      chk($sformatf("u%0d.LHBL", i),     int'(lhbl_o[i]),  elh);
      chk($sformatf("u%0d.LVBL", i),     int'(lvbl_o[i]),  elv);
      chk($sformatf("u%0d.HS", i),       int'(hs_o[i]),    ehs);
      chk($sformatf("u%0d.VS", i),       int'(vs_o[i]),    evs);
      chk($sformatf("u%0d.frame", i),    int'(fr_o[i]),    efr);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 3; i++) begin pc[i] = 0; p2[i] = 0; end
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (enable) begin
      n++;
      for (int i = 0; i < 3; i++) begin
        pc[i] = int'(n % D[i] == 0);
        p2[i] = int'(n % (D[i] / 2) == 0);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin pc[i] = 0; p2[i] = 0; end
    end
    #1;
    compare_all();
  endtask

  initial begin
    int found, t;
    checks = 0; failures = 0;
    rst = 1'b1; enable = 1'b1;
    model_reset();
    repeat (3) tick();
    chk("rst_hcnt", int'(h0), 0);
    chk("rst_LHBL", int'(lhbl_o[0]), 1);
    chk("rst_LVBL", int'(lvbl_o[0]), 0);
    chk("rst_cen",  int'(cen_o[0]), 0);

    @(negedge clk); rst = 1'b0;
    repeat (4) tick();
    chk("first_cen_e4", int'(cen_o[0]), 1);
    chk("cen2_aligned", int'(cen2_o[0]), 1);
    chk("hcnt_hold_e4", int'(h0), 0);
    tick();
    chk("hcnt_adv_e5", int'(h0), 1);
    repeat (1700) tick();

    found = 0;
    for (int k = 0; k < 3000 && found == 0; k++) begin
      tick();
      if (h0 == 9'd100 && cen_o[0] == 1'b0) found = 1;
    end
    chk("wait_h100", found, 1);
    if (found == 1) begin
      t = 1;
      @(negedge clk); enable = 1'b0;
      repeat (10) begin
        tick(); t++;
        chk("gap_hcnt", int'(h0), 100);
        chk("gap_cen", int'(cen_o[0]), 0);
      end
      @(negedge clk); enable = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && found == 0; k++) begin
        tick(); t++;
        if (cen_o[0]) found = 1;
      end
      chk("gap_pulse_seen", found, 1);
      chk("gap_spacing", t, 14);
    end

    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    @(negedge clk); enable = 1'b1;
    repeat (9000) tick();

    // Asynchronous reset mid-frame: state must clear before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    chk("arst_hcnt",  int'(h0), 0);
    chk("arst_vcnt",  int'(v2), 0);
    chk("arst_LVBL",  int'(lvbl_o[0]), 0);
    chk("arst_frame", int'(fr_o[2]), 0);
    tick();
    @(negedge clk); rst = 1'b0;
    repeat (2000) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
